// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for i2c_master: queues address/rw/data requests, launches them one
// at a time, and returns read data and status in order, with a per-transaction timeout.
module i2c_cmd_sequencer #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [2:0]  MASTER_IDLE    = 3'd0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [6:0]                   cmd_addr,
   input  logic                         cmd_rw,
   input  logic [7:0]                   cmd_wdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [7:0]                   rsp_rdata,
   output logic                         rsp_ack_error,
   output logic                         rsp_timeout,
   output logic                         m_start,
   output logic [6:0]                   m_addr,
   output logic                         m_rw,
   output logic [7:0]                   m_data_in,
   input  logic [7:0]                   m_data_out,
   input  logic                         m_ack_error,
   input  logic [2:0]                   m_state,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         busy
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef struct packed {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] wdata;
   } cmd_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_RESPOND
   } state_t;

   cmd_t            mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [TW-1:0]   tmo_cnt;
   state_t          state;

   logic            push_c;
   logic            pop_c;
   logic            tmo_hit_c;
   logic            to_idle_c;
   logic [CW-1:0]   count_nxt_c;

   assign push_c    = cmd_valid && cmd_ready;
   assign pop_c     = (state == S_IDLE) && (fifo_count != '0) && (m_state == MASTER_IDLE);
   assign tmo_hit_c = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign to_idle_c = ((state == S_IDLE) && !pop_c) || ((state == S_RESPOND) && rsp_ready);

   // Occupancy after this cycle's push/pop; drives the registered ready and busy flags.
   always_comb begin
      count_nxt_c = fifo_count;
      if (push_c && !pop_c) begin
         count_nxt_c = fifo_count + CW'(1);
      end else if (!push_c && pop_c) begin
         count_nxt_c = fifo_count - CW'(1);
      end
   end

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= '{addr: cmd_addr, rw: cmd_rw, wdata: cmd_wdata};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         cmd_ready     <= 1'b1;
         busy          <= 1'b0;
         tmo_cnt       <= '0;
         m_start       <= 1'b0;
         m_addr        <= '0;
         m_rw          <= 1'b0;
         m_data_in     <= '0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_ack_error <= 1'b0;
         rsp_timeout   <= 1'b0;
      end else begin
         fifo_count <= count_nxt_c;
         cmd_ready  <= (count_nxt_c != CW'(DEPTH));
         busy       <= !to_idle_c || (count_nxt_c != '0);
         m_start    <= 1'b0;
         if (push_c) begin
            wr_ptr <= wr_ptr + PW'(1);
         end

         case (state)
            S_IDLE: begin
               if (pop_c) begin
                  m_addr    <= mem[rd_ptr].addr;
                  m_rw      <= mem[rd_ptr].rw;
                  m_data_in <= mem[rd_ptr].wdata;
                  rd_ptr    <= rd_ptr + PW'(1);
                  m_start   <= 1'b1;
                  state     <= S_LAUNCH;
               end
            end

            S_LAUNCH: begin
               tmo_cnt <= '0;
               state   <= S_WAIT_BUSY;
            end

            // Timeout wins over a completion seen in the same cycle.
            S_WAIT_BUSY: begin
               if (tmo_hit_c) begin
                  rsp_rdata     <= '0;
                  rsp_ack_error <= 1'b0;
                  rsp_timeout   <= 1'b1;
                  rsp_valid     <= 1'b1;
                  state         <= S_RESPOND;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
                  if (m_state != MASTER_IDLE) begin
                     state <= S_WAIT_DONE;
                  end
               end
            end

            S_WAIT_DONE: begin
               if (tmo_hit_c) begin
                  rsp_rdata     <= '0;
                  rsp_ack_error <= 1'b0;
                  rsp_timeout   <= 1'b1;
                  rsp_valid     <= 1'b1;
                  state         <= S_RESPOND;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
                  if (m_state == MASTER_IDLE) begin
                     rsp_rdata     <= m_rw ? m_data_out : 8'h00;
                     rsp_ack_error <= m_ack_error;
                     rsp_timeout   <= 1'b0;
                     rsp_valid     <= 1'b1;
                     state         <= S_RESPOND;
                  end
               end
            end

            S_RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: behavioural i2c_master stand-in, a table of
// single-transaction vectors, and hand-written sequences for the multi-cycle corners.
module tb_i2c_cmd_sequencer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 16;
   localparam logic [6:0]  NO_SLAVE = 7'h10;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [6:0] cmd_addr = '0;
   logic       cmd_rw = 1'b0;
   logic [7:0] cmd_wdata = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_rdata;
   logic       rsp_ack_error;
   logic       rsp_timeout;
   logic       m_start;
   logic [6:0] m_addr;
   logic       m_rw;
   logic [7:0] m_data_in;
   logic [7:0] m_data_out;
   logic       m_ack_error;
   logic [2:0] m_state;
   logic [2:0] fifo_count;
   logic       busy;

   i2c_cmd_sequencer #(
      .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .MASTER_IDLE(3'd0)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_ack_error(rsp_ack_error), .rsp_timeout(rsp_timeout),
      .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
      .m_data_out(m_data_out), .m_ack_error(m_ack_error), .m_state(m_state),
      .fifo_count(fifo_count), .busy(busy)
   );

   always #5 clk = ~clk;

   // Master stand-in: busy for busy_len+1 cycles after start, or forever while hang is set.
   logic       hang = 1'b0;
   int         busy_len = 3;
   int         mst_cnt;
   int         start_cnt = 0;
   logic [7:0] slave_mem [128];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state     <= 3'd0;
         mst_cnt     <= 0;
         m_data_out  <= 8'h00;
         m_ack_error <= 1'b0;
      end else if (m_start) begin
         m_state     <= 3'd1;
         mst_cnt     <= busy_len;
         m_ack_error <= (m_addr == NO_SLAVE);
         m_data_out  <= m_rw ? slave_mem[m_addr] : 8'hEE;
      end else if (m_state != 3'd0 && !hang) begin
         if (mst_cnt == 0) m_state <= 3'd0;
         else              mst_cnt <= mst_cnt - 1;
      end
   end

   always @(posedge clk) begin
      if (m_start) start_cnt <= start_cnt + 1;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [6:0] a, input logic rw, input logic [7:0] d);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_rw    = rw;
      cmd_wdata = d;
      while (!cmd_ready && n < 200) begin
         tick();
         n++;
      end
      if (!cmd_ready) begin
         fail_bound("cmd_accept");
         cmd_valid = 1'b0;
         return;
      end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [7:0] rd, output logic ae, output logic to);
      int n = 0;
      rsp_ready = 1'b1;
      while (!rsp_valid && n < 200) begin
         tick();
         n++;
      end
      if (!rsp_valid) begin
         fail_bound("rsp_wait");
         rsp_ready = 1'b0;
         rd = 8'hXX; ae = 1'bx; to = 1'bx;
         return;
      end
      rd = rsp_rdata;
      ae = rsp_ack_error;
      to = rsp_timeout;
      tick();
      rsp_ready = 1'b0;
      check("rsp_valid_clears", 32'(rsp_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"},  32'(cmd_ready),     32'd1);
      check({tag, "_rsp_valid"},  32'(rsp_valid),     32'd0);
      check({tag, "_rsp_rdata"},  32'(rsp_rdata),     32'd0);
      check({tag, "_rsp_ack"},    32'(rsp_ack_error), 32'd0);
      check({tag, "_rsp_tmo"},    32'(rsp_timeout),   32'd0);
      check({tag, "_m_start"},    32'(m_start),       32'd0);
      check({tag, "_m_addr"},     32'(m_addr),        32'd0);
      check({tag, "_m_rw"},       32'(m_rw),          32'd0);
      check({tag, "_m_data_in"},  32'(m_data_in),     32'd0);
      check({tag, "_fifo_count"}, 32'(fifo_count),    32'd0);
      check({tag, "_busy"},       32'(busy),          32'd0);
   endtask

   typedef struct {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_ack;
      logic       exp_to;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      logic       ae;
      logic       to;
      int         s0;
      int         n;
      int         bad;

      for (int i = 0; i < 128; i++) slave_mem[i] = 8'(i * 3 + 1);
      slave_mem[7'h55] = 8'h93;
      slave_mem[7'h2A] = 8'h3C;

      vecs[0] = '{addr: 7'h55, rw: 1'b1, wdata: 8'h00, exp_rdata: 8'h93, exp_ack: 1'b0, exp_to: 1'b0};
      vecs[1] = '{addr: 7'h10, rw: 1'b0, wdata: 8'h5A, exp_rdata: 8'h00, exp_ack: 1'b1, exp_to: 1'b0};
      vecs[2] = '{addr: 7'h2A, rw: 1'b1, wdata: 8'hFF, exp_rdata: 8'h3C, exp_ack: 1'b0, exp_to: 1'b0};
      vecs[3] = '{addr: 7'h2A, rw: 1'b0, wdata: 8'h11, exp_rdata: 8'h00, exp_ack: 1'b0, exp_to: 1'b0};
      vecs[4] = '{addr: 7'h10, rw: 1'b0, wdata: 8'h77, exp_rdata: 8'h00, exp_ack: 1'b1, exp_to: 1'b0};
      vecs[5] = '{addr: 7'h03, rw: 1'b1, wdata: 8'h12, exp_rdata: 8'h0A, exp_ack: 1'b0, exp_to: 1'b0};

      // Reset values, during and after reset
      repeat (3) tick();
      check_reset_outputs("in_reset");
      reset = 1'b1;
      repeat (2) tick();
      check_reset_outputs("post_reset");

      // Write: start pulse two cycles after accept, single cycle wide
      send_cmd(7'h55, 1'b0, 8'h2B);
      check("lat_count_n1", 32'(fifo_count), 32'd1);
      check("lat_start_n1", 32'(m_start), 32'd0);
      check("lat_busy_n1", 32'(busy), 32'd1);
      tick();
      check("lat_start_n2", 32'(m_start), 32'd1);
      check("lat_m_addr", 32'(m_addr), 32'h55);
      check("lat_m_rw", 32'(m_rw), 32'd0);
      check("lat_m_data_in", 32'(m_data_in), 32'h2B);
      tick();
      check("lat_start_n3", 32'(m_start), 32'd0);
      get_rsp(rd, ae, to);
      check("wr_rdata", 32'(rd), 32'h00);
      check("wr_ack", 32'(ae), 32'd0);
      check("wr_tmo", 32'(to), 32'd0);
      check("wr_busy_after", 32'(busy), 32'd0);

      // Table of single transactions with varied master latency
      for (int i = 0; i < 6; i++) begin
         busy_len = i + 1;
         send_cmd(vecs[i].addr, vecs[i].rw, vecs[i].wdata);
         get_rsp(rd, ae, to);
         check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
         check($sformatf("vec%0d_ack", i),   32'(ae), 32'(vecs[i].exp_ack));
         check($sformatf("vec%0d_tmo", i),   32'(to), 32'(vecs[i].exp_to));
         check($sformatf("vec%0d_m_addr_hold", i), 32'(m_addr), 32'(vecs[i].addr));
      end

      // Full/ordering: one in flight plus DEPTH queued under response backpressure
      busy_len = 2;
      s0 = start_cnt;
      for (int i = 0; i < 5; i++) send_cmd(7'(7'h20 + i), 1'b1, 8'h00);
      check("full_count", 32'(fifo_count), 32'd4);
      check("full_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1;
      cmd_addr  = 7'h25;
      cmd_rw    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("full_hold%0d_ready", i), 32'(cmd_ready), 32'd0);
         check($sformatf("full_hold%0d_count", i), 32'(fifo_count), 32'd4);
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         get_rsp(rd, ae, to);
         check($sformatf("order%0d_rdata", i), 32'(rd), 32'(slave_mem[7'h20 + i]));
         check($sformatf("order%0d_starts", i), 32'(start_cnt - s0), 32'(i + 1));
      end
      check("order_count_empty", 32'(fifo_count), 32'd0);

      // Timeout with master stuck busy; queued command waits for master idle
      hang = 1'b1;
      send_cmd(7'h55, 1'b0, 8'h2B);
      send_cmd(7'h20, 1'b1, 8'h00);
      n = 0;
      while (!m_start && n < 50) begin
         tick();
         n++;
      end
      if (!m_start) fail_bound("tmo_start");
      n = 0;
      while (!rsp_valid && n < 40) begin
         tick();
         n++;
      end
      check("tmo_latency", 32'(n), 32'd17);
      check("tmo_queued", 32'(fifo_count), 32'd1);
      get_rsp(rd, ae, to);
      check("tmo_flag", 32'(to), 32'd1);
      check("tmo_rdata", 32'(rd), 32'd0);
      check("tmo_ack", 32'(ae), 32'd0);
      s0 = start_cnt;
      repeat (6) tick();
      check("tmo_no_launch_while_busy", 32'(start_cnt - s0), 32'd0);
      hang = 1'b0;
      get_rsp(rd, ae, to);
      check("tmo_next_rdata", 32'(rd), 32'(slave_mem[7'h20]));
      check("tmo_next_flag", 32'(to), 32'd0);
      check("tmo_next_launched", 32'(start_cnt - s0), 32'd1);

      // Reset asserted mid-transaction with two commands queued
      busy_len = 8;
      send_cmd(7'h55, 1'b1, 8'h00);
      send_cmd(7'h21, 1'b1, 8'h00);
      send_cmd(7'h22, 1'b0, 8'h44);
      repeat (2) tick();
      check("rst_pre_count", 32'(fifo_count), 32'd2);
      check("rst_pre_busy", 32'(busy), 32'd1);
      check("rst_pre_m_addr", 32'(m_addr), 32'h55);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      tick();
      reset = 1'b1;
      rsp_ready = 1'b1;
      bad = 0;
      repeat (30) begin
         tick();
         if (rsp_valid || m_start) bad++;
      end
      rsp_ready = 1'b0;
      check("rst_no_activity", 32'(bad), 32'd0);
      check("rst_post_count", 32'(fifo_count), 32'd0);
      check("rst_post_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
